// File: rtl/posit_mult_pkg.sv
// Shared constants for the posit multiply pipeline: word geometry,
// packed operand field offsets and flag bit positions.
package posit_mult_pkg;

  localparam int WIDTH   = 8;
  localparam int EXP     = 2;
  localparam int N_LANES = 4;

  // Signed regime width, stored fraction width, packed field width, scale width
  localparam int REGI = $clog2(WIDTH) + 1;
  localparam int MTS  = WIDTH - 3 - EXP;
  localparam int FLD  = 1 + REGI + EXP + MTS;
  localparam int SCL  = REGI + EXP + 2;

  // Packed operand layout {sign, k, exp, mts}, LSB first
  localparam int MTS_O  = 0;
  localparam int EXP_O  = MTS_O + MTS;
  localparam int K_O    = EXP_O + EXP;
  localparam int SIGN_O = K_O + REGI;

  // Per-lane flag pair {nar, zero}
  localparam int NAR_B  = 1;
  localparam int ZERO_B = 0;

endpackage

// File: rtl/posit_mult_if.sv
// Operand/result bus of the posit multiply pipeline.
// Handshake: a transfer happens on a rising clock edge where valid and
// ready are both high; a producer holding valid keeps its payload stable,
// and ready never depends combinationally on the same side's valid.
interface posit_mult_if import posit_mult_pkg::*; #(
  parameter int LANES = N_LANES
) ();

  logic                   in_valid;
  logic                   in_ready;
  logic [LANES*FLD-1:0]   a_fld;
  logic [LANES*FLD-1:0]   b_fld;
  logic [2*LANES-1:0]     a_flag;
  logic [2*LANES-1:0]     b_flag;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES-1:0]       out_sign;
  logic [LANES*SCL-1:0]   out_scale;
  logic [LANES*MTS-1:0]   out_mts;
  logic [2*LANES-1:0]     out_flag;

  modport master (
    output in_valid, a_fld, b_fld, a_flag, b_flag, out_ready,
    input  in_ready, out_valid, out_sign, out_scale, out_mts, out_flag
  );

  modport slave (
    input  in_valid, a_fld, b_fld, a_flag, b_flag, out_ready,
    output in_ready, out_valid, out_sign, out_scale, out_mts, out_flag
  );

endinterface

// File: rtl/posit_mult_lane.sv
// One multiply lane: stage 1 forms sign, regime sum, exponent sum and the
// full mantissa product; stage 2 normalises, optionally rounds, builds the
// combined scale and applies the NaR/zero override.
// Build option: POSIT_MULT_ROUND_EN selects round-to-nearest-even of the
// fraction instead of truncation.
module posit_mult_lane import posit_mult_pkg::*; (
  input  logic           clk_i,
  input  logic           rstn,
  input  logic           i_en1,
  input  logic           i_en2,
  input  logic [FLD-1:0] i_a_fld,
  input  logic [FLD-1:0] i_b_fld,
  input  logic [1:0]     i_a_flag,
  input  logic [1:0]     i_b_flag,
  output logic           o_sign,
  output logic [SCL-1:0] o_scale,
  output logic [MTS-1:0] o_mts,
  output logic [1:0]     o_flag
);

`ifdef POSIT_MULT_ROUND_EN
  localparam logic RND_EN = 1'b1;
`else
  localparam logic RND_EN = 1'b0;
`endif

  localparam int PW = 2 * (MTS + 1);

  // Stage 1 operand decode and product
  logic [REGI-1:0] w_ka, w_kb;
  logic [PW-1:0]   w_p;
  logic            w_nar;

  assign w_ka  = i_a_fld[K_O +: REGI];
  assign w_kb  = i_b_fld[K_O +: REGI];
  assign w_p   = {{(MTS+1){1'b0}}, 1'b1, i_a_fld[MTS_O +: MTS]} *
                 {{(MTS+1){1'b0}}, 1'b1, i_b_fld[MTS_O +: MTS]};
  assign w_nar = i_a_flag[NAR_B] | i_b_flag[NAR_B];

  logic            r_sign1;
  logic [REGI:0]   r_ksum;
  logic [EXP:0]    r_esum;
  logic [PW-1:0]   r_p;
  logic            r_nar1;
  logic            r_zero1;

  // Stage 1 register: captures one operand set per accepted transfer
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      r_sign1 <= 1'b0;
      r_ksum  <= '0;
      r_esum  <= '0;
      r_p     <= '0;
      r_nar1  <= 1'b0;
      r_zero1 <= 1'b0;
    end else if (i_en1) begin
      r_sign1 <= i_a_fld[SIGN_O] ^ i_b_fld[SIGN_O];
      r_ksum  <= {w_ka[REGI-1], w_ka} + {w_kb[REGI-1], w_kb};
      r_esum  <= {1'b0, i_a_fld[EXP_O +: EXP]} + {1'b0, i_b_fld[EXP_O +: EXP]};
      r_p     <= w_p;
      r_nar1  <= w_nar;
      r_zero1 <= ~w_nar & (i_a_flag[ZERO_B] | i_b_flag[ZERO_B]);
    end
  end

  // Stage 2 normalisation: product is 01.x or 1x.x, drop the leading one
  logic            w_norm;
  logic [2*MTS:0]  w_f;
  logic [MTS-1:0]  w_trunc;
  logic            w_inc;
  logic [MTS:0]    w_rnd;
  logic [SCL-1:0]  w_kext;
  logic [SCL-1:0]  w_scale;

  assign w_norm  = r_p[PW-1];
  assign w_f     = w_norm ? r_p[2*MTS:0] : {r_p[2*MTS-1:0], 1'b0};
  assign w_trunc = w_f[2*MTS -: MTS];
  // Guard is the first dropped bit; ties go to the even fraction
  assign w_inc   = RND_EN & w_f[MTS] & ((|w_f[MTS-1:0]) | w_trunc[0]);
  // A carry out of the fraction wraps it to zero and bumps the scale
  assign w_rnd   = {1'b0, w_trunc} + {{MTS{1'b0}}, w_inc};
  assign w_kext  = {{(SCL-REGI-1){r_ksum[REGI]}}, r_ksum};
  assign w_scale = (w_kext << EXP)
                 + {{(SCL-EXP-1){1'b0}}, r_esum}
                 + {{(SCL-1){1'b0}}, w_norm}
                 + {{(SCL-1){1'b0}}, w_rnd[MTS]};

  logic            r_sign2;
  logic [SCL-1:0]  r_scale2;
  logic [MTS-1:0]  r_mts2;
  logic [1:0]      r_flag2;

  // Stage 2 register: special values report only their flag
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      r_sign2  <= 1'b0;
      r_scale2 <= '0;
      r_mts2   <= '0;
      r_flag2  <= 2'b00;
    end else if (i_en2) begin
      r_flag2 <= {r_nar1, r_zero1};
      if (r_nar1 | r_zero1) begin
        r_sign2  <= 1'b0;
        r_scale2 <= '0;
        r_mts2   <= '0;
      end else begin
        r_sign2  <= r_sign1;
        r_scale2 <= w_scale;
        r_mts2   <= w_rnd[MTS-1:0];
      end
    end
  end

  assign o_sign  = r_sign2;
  assign o_scale = r_scale2;
  assign o_mts   = r_mts2;
  assign o_flag  = r_flag2;

endmodule

// File: rtl/posit_mult_pipe.sv
// Multi-lane two-stage posit field multiplier with valid/ready flow
// control. All lanes advance together under one pair of stage valid bits.
// Build option: POSIT_MULT_ROUND_EN enables fraction rounding in each lane.
module posit_mult_pipe import posit_mult_pkg::*; #(
  parameter int LANES = N_LANES
) (
  input  logic         clk_i,
  input  logic         rstn,
  posit_mult_if.slave  bus
);

  logic r_v1, r_v2;
  logic w_ld1, w_ld2, w_acc;

  // A stage loads when it is empty or the stage after it is moving
  assign w_ld2        = ~r_v2 | bus.out_ready;
  assign w_ld1        = ~r_v1 | w_ld2;
  assign w_acc        = bus.in_valid & w_ld1;
  assign bus.in_ready = w_ld1;
  assign bus.out_valid = r_v2;

  // Stage occupancy bits
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      if (w_ld1) r_v1 <= w_acc;
      if (w_ld2) r_v2 <= r_v1;
    end
  end

  logic [LANES-1:0]     w_sign;
  logic [LANES*SCL-1:0] w_scale;
  logic [LANES*MTS-1:0] w_mts;
  logic [2*LANES-1:0]   w_flag;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    posit_mult_lane u_lane (
      .clk_i    (clk_i),
      .rstn     (rstn),
      .i_en1    (w_acc),
      .i_en2    (w_ld2 & r_v1),
      .i_a_fld  (bus.a_fld[g*FLD +: FLD]),
      .i_b_fld  (bus.b_fld[g*FLD +: FLD]),
      .i_a_flag (bus.a_flag[2*g +: 2]),
      .i_b_flag (bus.b_flag[2*g +: 2]),
      .o_sign   (w_sign[g]),
      .o_scale  (w_scale[g*SCL +: SCL]),
      .o_mts    (w_mts[g*MTS +: MTS]),
      .o_flag   (w_flag[2*g +: 2])
    );
  end

  assign bus.out_sign  = w_sign;
  assign bus.out_scale = w_scale;
  assign bus.out_mts   = w_mts;
  assign bus.out_flag  = w_flag;

endmodule
